// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed common-anode 7-segment scan driver
// Shadow-registered digit nibbles, one digit per refresh period, active-low outputs.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_suppress,
  input  logic                    hex_en,
  input  logic                    load,
  output logic [6:0]              segs,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic                    lz_q, lz_d, hex_q, hex_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d, idx_nxt;
  logic [6:0]              segs_q, segs_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_q, frame_d;
  logic                    tick, mask_bit, upper_zero, blank;
  logic [3:0]              nib;

  function automatic logic [6:0] glyph(input logic [3:0] code);
    case (code)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    value_d = value_q;
    blank_d = blank_q;
    lz_d    = lz_q;
    hex_d   = hex_q;
    if (load) begin
      value_d = value;
      blank_d = blank_mask;
      lz_d    = lz_suppress;
      hex_d   = hex_en;
    end

    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_nxt = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;

    // Decode from the registered shadow so a load on the tick edge only shows next tick.
    nib        = 4'h0;
    mask_bit   = 1'b0;
    upper_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_nxt == IW'(k)) begin
        nib      = value_q[4*k +: 4];
        mask_bit = blank_q[k];
      end
      if ((IW'(k) >= idx_nxt) && (value_q[4*k +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
    blank = mask_bit || (!hex_q && (nib >= 4'd10)) ||
            (lz_q && (idx_nxt != '0) && upper_zero);

    idx_d   = idx_q;
    segs_d  = segs_q;
    an_d    = an_q;
    frame_d = 1'b0;
    if (tick) begin
      idx_d   = idx_nxt;
      an_d    = ~(NUM_DIGITS'(1) << idx_nxt);
      segs_d  = blank ? 7'b1111111 : glyph(nib);
      frame_d = (idx_nxt == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      blank_q <= '0;
      lz_q    <= 1'b0;
      hex_q   <= 1'b0;
      presc_q <= '0;
      idx_q   <= IDX_MAX;
      segs_q  <= 7'b1111111;
      an_q    <= '1;
      frame_q <= 1'b0;
    end else begin
      value_q <= value_d;
      blank_q <= blank_d;
      lz_q    <= lz_d;
      hex_q   <= hex_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      segs_q  <= segs_d;
      an_q    <= an_d;
      frame_q <= frame_d;
    end
  end

  assign segs       = segs_q;
  assign an         = an_q;
  assign frame_tick = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver
// Stimulus pushes expected scan updates; a negedge monitor pops and compares them.
module tb_seg7_scan_driver;
  localparam int N = 4;
  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  blank_mask = '0;
  logic        lz_suppress = 1'b0;
  logic        hex_en = 1'b0;
  logic        load = 1'b0;
  logic [6:0]  segs;
  logic [3:0]  an;
  logic        frame_tick;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .blank_mask(blank_mask),
    .lz_suppress(lz_suppress), .hex_en(hex_en), .load(load),
    .segs(segs), .an(an), .frame_tick(frame_tick)
  );

  int errors = 0;
  int checks = 0;
  int pushes = 0;
  int pops = 0;
  int edge_cnt = 0;
  int tick_cnt = 0;
  logic [11:0] exp_q[$];

  logic [6:0] glyph_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // Model shadow registers
  logic [15:0] m_val = '0;
  logic [3:0]  m_bm = '0;
  logic        m_lz = 1'b0;
  logic        m_hx = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] model_segs(input int k);
    logic [15:0] s;
    logic [3:0]  code;
    s    = m_val >> (4 * k);
    code = s[3:0];
    if (m_bm[k] || (!m_hx && code >= 4'd10) || (m_lz && k != 0 && s == 16'h0))
      return 7'b1111111;
    return glyph_tab[code];
  endfunction

  // One clock edge of the model: a tick every R edges since release, digit = (ticks-1) mod N.
  task automatic cyc();
    int k;
    logic [3:0] ea;
    logic       ef;
    @(posedge clk);
    if (rst_n) begin
      edge_cnt++;
      if (edge_cnt % R == 0) begin
        tick_cnt++;
        k  = (tick_cnt - 1) % N;
        ea = ~(4'b0001 << k);
        ef = (k == 0);
        exp_q.push_back({ea, model_segs(k), ef});
        pushes++;
      end
      if (load) begin
        m_val = value;
        m_bm  = blank_mask;
        m_lz  = lz_suppress;
        m_hx  = hex_en;
      end
    end
    #1;
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    #1;
    check("rst_segs", 32'(segs), 32'h7F);
    check("rst_an", 32'(an), 32'hF);
    check("rst_frame", 32'(frame_tick), 32'h0);
    repeat (hold) @(posedge clk);
    #1;
    exp_q.delete();
    m_val = '0; m_bm = '0; m_lz = 1'b0; m_hx = 1'b0;
    edge_cnt = 0;
    tick_cnt = 0;
    load = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic load_run(input logic [15:0] v, input logic [3:0] bm,
                          input logic lz, input logic hx, input int n);
    value = v; blank_mask = bm; lz_suppress = lz; hex_en = hx; load = 1'b1;
    cyc();
    load = 1'b0;
    repeat (n) cyc();
  endtask

  // Monitor: a change of an marks a scan update; otherwise outputs must hold.
  logic [3:0] prev_an = 4'hF;
  logic [6:0] prev_segs = 7'h7F;
  always @(negedge clk) begin
    logic [11:0] e;
    if (rst_n) begin
      if (an !== prev_an) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_update: an=%b segs=%b with no expected entry at %0t", an, segs, $time);
        end else begin
          e = exp_q.pop_front();
          pops++;
          check("scan_an", 32'(an), 32'(e[11:8]));
          check("scan_segs", 32'(segs), 32'(e[7:1]));
          check("scan_frame", 32'(frame_tick), 32'(e[0]));
        end
      end else begin
        check("segs_hold", 32'(segs), 32'(prev_segs));
        check("frame_idle", 32'(frame_tick), 32'h0);
      end
    end
    prev_an   = an;
    prev_segs = segs;
  end

  initial begin
    #3;
    do_reset(2);
    repeat (20) cyc();
    load_run(16'h1234, 4'b0000, 1'b0, 1'b0, 40);
    load_run(16'h00AF, 4'b0000, 1'b0, 1'b0, 20);
    load_run(16'h00AF, 4'b0000, 1'b0, 1'b1, 20);
    load_run(16'h0050, 4'b0000, 1'b1, 1'b1, 20);
    load_run(16'h0000, 4'b0000, 1'b1, 1'b0, 20);
    load_run(16'h8888, 4'b0101, 1'b0, 1'b0, 20);
    // Load mid-dwell, then load coincident with a tick edge, then async reset mid-dwell.
    repeat (5) cyc();
    load_run(16'h9999, 4'b0000, 1'b0, 1'b0, 0);
    repeat (3) cyc();
    while (edge_cnt % R != R - 1) cyc();
    load_run(16'hCDEF, 4'b0000, 1'b0, 1'b1, 10);
    do_reset(3);
    repeat (24) cyc();

    for (int i = 0; i < 1500; i++) begin
      for (int d = 0; d < N; d++)
        value[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      blank_mask  = 4'($urandom_range(0, 15));
      lz_suppress = 1'($urandom_range(0, 1));
      hex_en      = 1'($urandom_range(0, 1));
      load        = ((i / 100) % 5 == 3) ? 1'b1 : ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 399) == 0) begin
        do_reset(1 + $urandom_range(0, 2));
      end else begin
        cyc();
      end
    end
    load = 1'b0;
    repeat (2) cyc();
    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    checks++;
    if (pops < 100) begin
      errors++;
      $display("FAIL update_count: got %0d updates expected at least 100", pops);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
